// File: rtl/ysyx_mem_pkg.sv
// Shared definitions for the LSU-facing scratchpad SRAM responder.
package ysyx_mem_pkg;

  localparam int LANES = 4;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RWAIT,
    S_RRESP,
    S_WWAIT,
    S_WRESP,
    S_TURN
  } mem_state_t;

endpackage

// File: rtl/ysyx_lsu_sram_array.sv
// Word-organised SRAM: synchronous read, synchronous byte-enabled write.
module ysyx_lsu_sram_array
  import ysyx_mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [LANES-1:0]     be,
  input  logic [8*LANES-1:0]   wdata,
  output logic [8*LANES-1:0]   rdata
);

  logic [8*LANES-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/ysyx_lsu_sram.sv
// LSU load/store bus responder backed by a scratchpad SRAM with programmable
// response latency; reads return whole words, stores are lane-aligned here.
module ysyx_lsu_sram
  import ysyx_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  input  logic [7:0]        rstrb,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        wstrb,
  input  logic              wvalid,
  output logic              wready_o,
  output logic              oor_o
);

  localparam int                IDX_W = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * MEM_WORDS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  // Bytes shifted past lane 3 fall off the top rather than wrapping.
  function automatic logic [LANES-1:0] lane_be(input logic [3:0] s, input logic [1:0] o);
    logic [2*LANES-1:0] t;
    t = {4'b0000, s} << o;
    return t[LANES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] lane_data(input logic [DATA_W-1:0] d, input logic [1:0] o);
    return d << {o, 3'b000};
  endfunction

  mem_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  logic               oor_q;
  logic [LANES-1:0]   be_q;
  logic [DATA_W-1:0]  wdat_q;
  logic               rsel_q;
  logic [DATA_W-1:0]  arr_rdata;
  logic               arr_re;
  logic               arr_we;
  logic               unused_ok;

  assign unused_ok = ^{rstrb, wstrb[7:4]};

  // The array is touched on the edge that leaves the final wait cycle, so its
  // read data and committed bytes line up with the response cycle.
  assign arr_re = (state == S_RWAIT) && (cnt == '0) && !oor_q;
  assign arr_we = (state == S_WWAIT) && (cnt == '0) && !oor_q;

  // Out-of-range reads present zero; the array output register is left alone.
  assign rdata_o = rsel_q ? arr_rdata : '0;

  ysyx_lsu_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk   (clk),
    .re    (arr_re),
    .we    (arr_we),
    .idx   (idx_q),
    .be    (be_q),
    .wdata (wdat_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      oor_q    <= 1'b0;
      be_q     <= '0;
      wdat_q   <= '0;
      rsel_q   <= 1'b0;
      rvalid_o <= 1'b0;
      wready_o <= 1'b0;
      oor_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      wready_o <= 1'b0;
      oor_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arvalid) begin
            idx_q <= word_idx(araddr);
            oor_q <= !in_range(araddr);
            cnt   <= CNT_W'(LATENCY);
            state <= S_RWAIT;
          end else if (awvalid && wvalid) begin
            idx_q  <= word_idx(awaddr);
            oor_q  <= !in_range(awaddr);
            be_q   <= lane_be(wstrb[3:0], awaddr[1:0]);
            wdat_q <= lane_data(wdata, awaddr[1:0]);
            cnt    <= CNT_W'(LATENCY);
            state  <= S_WWAIT;
          end
        end
        S_RWAIT: begin
          if (cnt == '0) begin
            state    <= S_RRESP;
            rvalid_o <= 1'b1;
            oor_o    <= oor_q;
            rsel_q   <= !oor_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WWAIT: begin
          if (cnt == '0) begin
            state    <= S_WRESP;
            wready_o <= 1'b1;
            oor_o    <= oor_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RRESP: state <= S_TURN;
        S_WRESP: state <= S_TURN;
        S_TURN:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_lsu_sram.sv
// Directed bench: one responder at LATENCY=1 (index 0) and one at LATENCY=3 (index 1).
module tb_ysyx_lsu_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr  [2];
  logic [31:0] awaddr  [2];
  logic [31:0] wdata   [2];
  logic [31:0] rdata   [2];
  logic [7:0]  rstrb   [2];
  logic [7:0]  wstrb   [2];
  logic        arvalid [2];
  logic        awvalid [2];
  logic        wvalid  [2];
  logic        rvalid  [2];
  logic        wready  [2];
  logic        oor     [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_lsu_sram #(.LATENCY(1)) dut0 (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .rstrb(rstrb[0]),
    .rdata_o(rdata[0]), .rvalid_o(rvalid[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .wvalid(wvalid[0]),
    .wready_o(wready[0]), .oor_o(oor[0])
  );

  ysyx_lsu_sram #(.LATENCY(3)) dut1 (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .rstrb(rstrb[1]),
    .rdata_o(rdata[1]), .rvalid_o(rvalid[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .wvalid(wvalid[1]),
    .wready_o(wready[1]), .oor_o(oor[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_oor, input string tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    araddr[d] = a;
    rstrb[d] = 8'h0f;
    arvalid[d] = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = rvalid[d];
    end
    arvalid[d] = 1'b0;
    chk({tag, " latency"}, 32'(n), (d == 0) ? 32'd3 : 32'd5);
    chk({tag, " rdata"}, rdata[d], exp);
    chk({tag, " oor"}, {31'b0, oor[d]}, {31'b0, exp_oor});
    @(posedge clk); #1;
    chk({tag, " rvalid one cycle"}, {31'b0, rvalid[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] dat,
                    input logic [7:0] s, input logic exp_oor, input string tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    awaddr[d] = a;
    wdata[d] = dat;
    wstrb[d] = s;
    awvalid[d] = 1'b1;
    wvalid[d] = 1'b1;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = wready[d];
    end
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    chk({tag, " latency"}, 32'(n), (d == 0) ? 32'd3 : 32'd5);
    chk({tag, " oor"}, {31'b0, oor[d]}, {31'b0, exp_oor});
    @(posedge clk); #1;
    chk({tag, " wready one cycle"}, {31'b0, wready[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic abort(input int d, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] dat, input string tag);
    int pulses;
    if (is_wr) begin
      awaddr[d] = a;
      wdata[d] = dat;
      wstrb[d] = 8'h0f;
      awvalid[d] = 1'b1;
      wvalid[d] = 1'b1;
    end else begin
      araddr[d] = a;
      arvalid[d] = 1'b1;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk({tag, " pulse under rst"}, {30'b0, rvalid[d], wready[d]}, 32'd0);
    @(posedge clk); #1;
    arvalid[d] = 1'b0;
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      pulses += int'(rvalid[d]) + int'(wready[d]);
    end
    chk({tag, " no pulse after rst"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    int rv_cnt, wr_cnt, rv_at, wr_at;
    for (int i = 0; i < 2; i++) begin
      araddr[i] = '0; awaddr[i] = '0; wdata[i] = '0;
      rstrb[i] = '0; wstrb[i] = '0;
      arvalid[i] = 1'b0; awvalid[i] = 1'b0; wvalid[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset rvalid", {31'b0, rvalid[i]}, 32'd0);
      chk("reset wready", {31'b0, wready[i]}, 32'd0);
      chk("reset oor", {31'b0, oor[i]}, 32'd0);
      chk("reset rdata", rdata[i], 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    wr(0, 32'h8000_0010, 32'hdeadbeef, 8'h0f, 1'b0, "sw word");
    rd(0, 32'h8000_0010, 32'hdeadbeef, 1'b0, "lw word");
    wr(0, 32'h8000_0013, 32'h0000_0055, 8'h01, 1'b0, "sb off3");
    rd(0, 32'h8000_0010, 32'h55adbeef, 1'b0, "lw after sb");

    wr(0, 32'h8000_0020, 32'h0000_0000, 8'h0f, 1'b0, "sw clear");
    wr(0, 32'h8000_0022, 32'h0000_1234, 8'h03, 1'b0, "sh off2");
    rd(0, 32'h8000_0020, 32'h1234_0000, 1'b0, "lw after sh");
    wr(0, 32'h8000_0021, 32'haabbccdd, 8'h0f, 1'b0, "sw off1");
    rd(0, 32'h8000_0020, 32'hbbccdd00, 1'b0, "lw after sw off1");

    rd(0, 32'h7fff_fffc, 32'h0000_0000, 1'b1, "lw below base");
    wr(0, 32'h8000_0000, 32'h1111_1111, 8'h0f, 1'b0, "sw word0");
    wr(0, 32'h8000_1000, 32'hffff_ffff, 8'h0f, 1'b1, "sw past end");
    rd(0, 32'h8000_0000, 32'h1111_1111, 1'b0, "lw word0 intact");
    wr(0, 32'h8000_0004, 32'h2222_2222, 8'h0f, 1'b0, "sw word1");
    chk("rdata held", rdata[0], 32'h1111_1111);

    // Read and write presented together and held through their responses.
    araddr[0] = 32'h8000_0010;
    awaddr[0] = 32'h8000_0030;
    wdata[0] = 32'hcafef00d;
    wstrb[0] = 8'h0f;
    arvalid[0] = 1'b1;
    awvalid[0] = 1'b1;
    wvalid[0] = 1'b1;
    rv_cnt = 0; wr_cnt = 0; rv_at = 0; wr_at = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (rvalid[0]) begin
        rv_cnt++;
        rv_at = n;
        chk("collide rdata", rdata[0], 32'h55adbeef);
        arvalid[0] = 1'b0;
      end
      if (wready[0]) begin
        wr_cnt++;
        wr_at = n;
        awvalid[0] = 1'b0;
        wvalid[0] = 1'b0;
      end
    end
    chk("collide rvalid count", 32'(rv_cnt), 32'd1);
    chk("collide rvalid edge", 32'(rv_at), 32'd3);
    chk("collide wready count", 32'(wr_cnt), 32'd1);
    chk("collide wready edge", 32'(wr_at), 32'd8);
    rd(0, 32'h8000_0030, 32'hcafef00d, 1'b0, "lw collide write");

    wr(1, 32'h8000_0040, 32'h0badf00d, 8'h0f, 1'b0, "lat3 sw");
    abort(1, 1'b0, 32'h8000_0040, 32'h0, "lat3 rst in rwait");
    rd(1, 32'h8000_0040, 32'h0badf00d, 1'b0, "lat3 lw after rst");
    abort(1, 1'b1, 32'h8000_0040, 32'h1234_5678, "lat3 rst in wwait");
    rd(1, 32'h8000_0040, 32'h0badf00d, 1'b0, "lat3 lw mem unchanged");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
